pe_mvm_seq: RTL and testbench
=============================

Name: pe_mvm_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 8x4 16-bit processing element.
- Computes a block matrix-vector product Q[j] = f(sum_k D[k]*W[j][k]) for NEU_OUT neurons over NEU_IN inputs.
- Uses NEU_OUT multipliers, one input column per cycle, instead of a full parallel multiplier/adder tree.
- Adds a start/busy/done handshake, rounding, saturation with a sticky overflow flag, and a selectable transfer function. Sits between the reservoir state buffer and the neuron-state writeback.

Parameters:
- WORD_LEN, 16, width of every D/W/Q element (<=18 so each multiplier maps to one embedded multiplier).
- NEU_IN, 8, inputs per neuron; any integer >=2, not restricted to powers of 2.
- NEU_OUT, 4, output neurons, equal to the number of parallel multipliers.
- FRAC_D, 12, fractional bits of D (Q3.12).
- FRAC_W, 15, fractional bits of W (Q0.15).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- ce  in  1  clock enable; 0 freezes all state and outputs.
- start  in  1  request a computation; accepted only in IDLE with ce=1.
- mode  in  2  transfer function, sampled with start.
- D  in  WORD_LEN*NEU_IN  neuron inputs; element k at [k*WORD_LEN +: WORD_LEN], signed.
- W  in  WORD_LEN*NEU_IN*NEU_OUT  synapses; element (j,k) at [(j*NEU_IN+k)*WORD_LEN +: WORD_LEN], signed.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when Q is updated.
- Q  out  WORD_LEN*NEU_OUT  results; channel j at [j*WORD_LEN +: WORD_LEN], signed.
- ovf  out  1  set if any channel saturated in the last run.

Behaviour:
- Reset (rst=1 at an edge, regardless of ce): state=IDLE; Q, busy, done, ovf, accumulators and counter all 0. Reset mid-run abandons the run; Q is not updated.
- States:
  - IDLE: start&ce latch D, W and mode into operand registers, clear accumulators, set k=0, go to MAC.
  - MAC: each ce cycle, acc[j] += Dreg[k]*Wreg[j][k] for all j, then k++. After the k=NEU_IN-1 accumulate, go to NORM.
  - NORM: compute results, register Q, set ovf, pulse done, return to IDLE.
- Latency: start edge e0, accumulate edges e1..e_NEU_IN, Q/done edge e_(NEU_IN+1). Total NEU_IN+2 edges with ce held high.
- Throughput: start asserted in the cycle done=1 is accepted at that edge (back-to-back runs). start while busy is ignored and is not queued.
- Operands are captured at e0; changes on D, W or mode during a run have no effect.
- ce=0: state, counter, accumulators, Q, busy, done and ovf all hold their values (a done pulse stretches across the stall).
- Arithmetic:
  - Products are full-precision signed, 2*WORD_LEN bits.
  - Accumulator width ACC_W = 2*WORD_LEN + clog2(NEU_IN); no internal overflow is possible.
  - Accumulator fractional bits F = FRAC_D + FRAC_W.
- mode 00 (linear, Q3.12 out): shift right by FRAC_W with round-half-up (add 2^(FRAC_W-1) before arithmetic shift), then saturate to a signed WORD_LEN value.
- mode 01 (hard tanh, Q0.15 out): shift right by FRAC_D with round-half-up, then saturate to [-2^(WORD_LEN-1), 2^(WORD_LEN-1)-1].
- mode 10 (ReLU, Q0.15 out): as mode 01, then negative results become 0.
- mode 11: identical to mode 01.
- ovf is written in NORM as the OR over channels of "saturation clamped this channel". ReLU zeroing does not set ovf. ovf is held until the next NORM or reset.
- Counter wraps only through the state change; non-power-of-2 NEU_IN must run exactly NEU_IN MAC cycles.

Test Plan:
- Reset: hold rst 2 cycles with ce=0 -> Q=0, busy=0, done=0, ovf=0.
- Defaults, mode=01, all D=0x1000, channel0 W all 0x1000, channel1 W all 0x0800, channels 2/3 W=0, start pulse at e0 -> done only at e9. Q0=0x7FFF (saturated), Q1=0x4000, Q2=Q3=0, ovf=1. busy high from e0 through e9.
- Same operands, mode=00 -> Q0=0x1000, Q1=0x0800, ovf=0. Rounding case: D0=0x0001, W(0,0)=0x4000, rest 0 -> accumulator 2^14 >> 15 rounds to Q0=0x0001.
- mode=10, channel0 W all 0xF000 with D=0x1000 -> sum -1.0 -> Q0=0x0000, ovf=0. Same run in mode=01 -> Q0=0x8000.
- Handshake: drop ce for 3 cycles during the 4th MAC cycle -> done arrives 3 cycles late with unchanged Q. start re-pulsed while busy -> ignored. start held in the done cycle -> second run completes 9 edges later.
- Reset mid-run: rst at the 3rd MAC cycle -> next edge busy=0, Q=0. A new start then completes with full latency and correct values.

Source files
------------

// File: rtl/pe_mvm_seq.sv
// Time-multiplexed matrix-vector processing element: NEU_OUT multipliers consume one
// input column per cycle, then round, saturate and apply the selected transfer function.
module pe_mvm_seq #(
  parameter int WORD_LEN = 16,
  parameter int NEU_IN   = 8,
  parameter int NEU_OUT  = 4,
  parameter int FRAC_D   = 12,
  parameter int FRAC_W   = 15
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ce,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic [WORD_LEN*NEU_IN-1:0]           D,
  input  logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]   W,
  output logic                                 busy,
  output logic                                 done,
  output logic [WORD_LEN*NEU_OUT-1:0]          Q,
  output logic                                 ovf
);

  localparam int ACC_W = 2*WORD_LEN + $clog2(NEU_IN);
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(NEU_IN);
  localparam int PRD_W = 2*WORD_LEN;

  localparam logic [CNT_W-1:0]        K_LAST  = CNT_W'(NEU_IN - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (WORD_LEN-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [SUM_W-1:0] RND_LIN = SUM_W'(1 << (FRAC_W-1));
  localparam logic signed [SUM_W-1:0] RND_ACT = SUM_W'(1 << (FRAC_D-1));

  typedef enum logic [1:0] {IDLE, MAC, NORM} state_t;
  typedef logic signed [WORD_LEN-1:0] word_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef struct packed {
    logic  clamped;
    word_t value;
  } sat_t;

  state_t                   state;
  logic [CNT_W-1:0]         k;
  logic [1:0]               mode_reg;
  word_t                    d_reg [NEU_IN];
  word_t                    w_reg [NEU_OUT][NEU_IN];
  acc_t                     acc   [NEU_OUT];
  logic signed [PRD_W-1:0]  prod  [NEU_OUT];
  word_t                    q_next [NEU_OUT];
  logic [NEU_OUT-1:0]       clamp_next;

  function automatic sat_t saturate(input logic signed [SUM_W-1:0] v);
    sat_t r;
    r.clamped = 1'b1;
    if (v > SAT_MAX)      r.value = SAT_MAX[WORD_LEN-1:0];
    else if (v < SAT_MIN) r.value = SAT_MIN[WORD_LEN-1:0];
    else begin
      r.clamped = 1'b0;
      r.value   = v[WORD_LEN-1:0];
    end
    return r;
  endfunction

  // The extra sign bit in ext keeps the rounding add from wrapping at the extremes.
  function automatic sat_t normalize(input acc_t a, input logic [1:0] m);
    logic signed [SUM_W-1:0] ext;
    sat_t r;
    ext = {a[ACC_W-1], a};
    case (m)
      2'b00:   r = saturate((ext + RND_LIN) >>> FRAC_W);
      2'b10: begin
        r = saturate((ext + RND_ACT) >>> FRAC_D);
        if (r.value[WORD_LEN-1]) r.value = '0;
      end
      default: r = saturate((ext + RND_ACT) >>> FRAC_D);
    endcase
    return r;
  endfunction

  always_comb begin
    for (int j = 0; j < NEU_OUT; j++)
      prod[j] = PRD_W'(d_reg[k]) * PRD_W'(w_reg[j][k]);
  end

  always_comb begin
    sat_t s;
    // NOTE: every variable driven here gets a value on every pass, so no latch is inferred.
    clamp_next = '0;
    for (int j = 0; j < NEU_OUT; j++) begin
      s             = normalize(acc[j], mode_reg);
      q_next[j]     = s.value;
      clamp_next[j] = s.clamped;
    end
  end

  // NOTE: operand registers carry no reset; they are always reloaded before a run uses them.
  always_ff @(posedge clk) begin
    if (!rst && ce && start && state == IDLE) begin
      mode_reg <= mode;
      for (int i = 0; i < NEU_IN; i++) begin
        d_reg[i] <= D[i*WORD_LEN +: WORD_LEN];
        for (int j = 0; j < NEU_OUT; j++)
          w_reg[j][i] <= W[(j*NEU_IN + i)*WORD_LEN +: WORD_LEN];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      Q     <= '0;
      for (int j = 0; j < NEU_OUT; j++) acc[j] <= '0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            busy  <= 1'b1;
            k     <= '0;
            for (int j = 0; j < NEU_OUT; j++) acc[j] <= '0;
          end
        end
        MAC: begin
          for (int j = 0; j < NEU_OUT; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
          if (k == K_LAST) begin
            state <= NORM;
            k     <= '0;
          end else begin
            k <= k + CNT_W'(1);
          end
        end
        NORM: begin
          for (int j = 0; j < NEU_OUT; j++) Q[j*WORD_LEN +: WORD_LEN] <= q_next[j];
          ovf   <= |clamp_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mvm_seq.sv
// Directed and randomised bench for pe_mvm_seq: expected results are queued at launch
// and compared when done pulses; handshake, stall and reset behaviour checked inline.
module tb_pe_mvm_seq;

  localparam int WL = 16;
  localparam int NI = 8;
  localparam int NO = 4;

  logic              clk = 1'b0;
  logic              rst, ce, start;
  logic [1:0]        mode;
  logic [WL*NI-1:0]  D;
  logic [WL*NI*NO-1:0] W;
  logic              busy, done, ovf;
  logic [WL*NO-1:0]  Q;

  typedef struct {
    logic [63:0] q;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  pe_mvm_seq #(.WORD_LEN(WL), .NEU_IN(NI), .NEU_OUT(NO), .FRAC_D(12), .FRAC_W(15)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .mode(mode), .D(D), .W(W),
    .busy(busy), .done(done), .Q(Q), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WL*NI-1:0] d_all(input logic [15:0] v);
    return {NI{v}};
  endfunction

  function automatic logic [WL*NI*NO-1:0] w_fill(input logic [15:0] c0, c1, c2, c3);
    return {{NI{c3}}, {NI{c2}}, {NI{c1}}, {NI{c0}}};
  endfunction

  // Behavioural reference: wide integer dot products, round-half-up, clamp, ReLU.
  function automatic void model(input logic [WL*NI-1:0] d, input logic [WL*NI*NO-1:0] w,
                                input logic [1:0] m, output logic [63:0] q, output logic o);
    longint s, r, one;
    int     sh;
    o   = 1'b0;
    q   = '0;
    one = 1;
    sh  = (m == 2'b00) ? 15 : 12;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI; i++)
        s += longint'(signed'(d[i*WL +: WL])) * longint'(signed'(w[(j*NI + i)*WL +: WL]));
      r = (s + (one <<< (sh - 1))) >>> sh;
      if (r > 32767)       begin r = 32767;  o = 1'b1; end
      else if (r < -32768) begin r = -32768; o = 1'b1; end
      if (m == 2'b10 && r < 0) r = 0;
      q[j*WL +: WL] = r[15:0];
    end
  endfunction

  task automatic launch(input logic [WL*NI-1:0] d, input logic [WL*NI*NO-1:0] w,
                        input logic [1:0] m, input logic [63:0] eq, input logic eo,
                        input bit push, input string tag);
    exp_t e;
    D = d; W = w; mode = m; start = 1'b1;
    if (push) begin
      e.q = eq; e.ovf = eo;
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    check({tag, " busy@e0"}, busy, 1'b1);
    check({tag, " done@e0"}, done, 1'b0);
  endtask

  // Counts edges until done (bounded), then pops the scoreboard and compares.
  task automatic finish_run(input string tag, input int exp_edges);
    int   n = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_edges));
    check({tag, " busy during run"}, busy_ok, 1'b1);
    tests++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " Q"}, Q, e.q);
      check({tag, " ovf"}, ovf, e.ovf);
    end
  endtask

  initial begin
    logic [WL*NI-1:0]    dr;
    logic [WL*NI*NO-1:0] wr;
    logic [1:0]          mr;
    logic [63:0]         qr;
    logic                orr;
    bit                  extra;

    rst = 1'b1; ce = 1'b0; start = 1'b0; mode = 2'b00; D = '0; W = '0;
    tick(); tick();
    check("reset Q", Q, 64'h0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset ovf", ovf, 1'b0);
    rst = 1'b0; ce = 1'b1;
    tick();

    // Plan cases: hard tanh with saturation, linear, rounding boundaries, ReLU.
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h0800, 16'h0, 16'h0), 2'b01,
           64'h0000_0000_4000_7FFF, 1'b1, 1'b1, "tanh sat");
    finish_run("tanh sat", NI + 1);
    tick();
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h0800, 16'h0, 16'h0), 2'b00,
           64'h0000_0000_0800_1000, 1'b0, 1'b1, "linear");
    finish_run("linear", NI + 1);
    launch(128'h0001, 512'h4000, 2'b00, 64'h0000_0000_0000_0001, 1'b0, 1'b1, "round half up");
    finish_run("round half up", NI + 1);
    launch(128'h0001, 512'h3FFF, 2'b00, 64'h0, 1'b0, 1'b1, "round below half");
    finish_run("round below half", NI + 1);
    launch(128'hFFFF, 512'h4000, 2'b00, 64'h0, 1'b0, 1'b1, "round neg half");
    finish_run("round neg half", NI + 1);
    launch(128'hFFFF, 512'h4001, 2'b00, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1, "round neg");
    finish_run("round neg", NI + 1);
    launch(d_all(16'h1000), w_fill(16'hF000, 16'h0800, 16'h0, 16'h0), 2'b10,
           64'h0000_0000_4000_0000, 1'b0, 1'b1, "relu");
    finish_run("relu", NI + 1);
    launch(d_all(16'h1000), w_fill(16'hF000, 16'h0800, 16'h0, 16'h0), 2'b01,
           64'h0000_0000_4000_8000, 1'b0, 1'b1, "tanh min");
    finish_run("tanh min", NI + 1);

    // ce stall during the 4th MAC cycle, with operand changes that must be ignored.
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h0800, 16'h0, 16'h0), 2'b00,
           64'h0000_0000_0800_1000, 1'b0, 1'b1, "stall");
    D = d_all(16'h7FFF); W = w_fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF); mode = 2'b01;
    tick(); tick(); tick();
    ce = 1'b0;
    tick(); tick(); tick();
    check("stall busy held", busy, 1'b1);
    check("stall done held", done, 1'b0);
    check("stall Q held", Q, 64'h0000_0000_4000_8000);
    ce = 1'b1;
    finish_run("stall", NI + 1 - 3);
    ce = 1'b0;
    tick();
    check("done stretched", done, 1'b1);
    check("Q during stretch", Q, 64'h0000_0000_0800_1000);
    ce = 1'b1;
    tick();
    check("done cleared", done, 1'b0);

    // start re-pulsed while busy is ignored and not queued.
    launch(d_all(16'h1000), w_fill(16'h0800, 16'h1000, 16'h0, 16'h0), 2'b00,
           64'h0000_0000_1000_0800, 1'b0, 1'b1, "busy start");
    tick(); tick();
    start = 1'b1; D = d_all(16'h2000);
    tick();
    start = 1'b0;
    finish_run("busy start", NI + 1 - 3);
    extra = 1'b0;
    repeat (12) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    check("no queued run", extra, 1'b0);

    // Back-to-back: start held in the done cycle.
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h0800, 16'h0, 16'h0), 2'b01,
           64'h0000_0000_4000_7FFF, 1'b1, 1'b1, "b2b first");
    finish_run("b2b first", NI + 1);
    launch(d_all(16'h1000), w_fill(16'h0800, 16'h0400, 16'hF800, 16'h0), 2'b00,
           64'h0000_F800_0400_0800, 1'b0, 1'b1, "b2b second");
    finish_run("b2b second", NI + 1);

    // Reset at the 3rd MAC cycle abandons the run.
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h1000, 16'h1000, 16'h1000), 2'b01,
           64'h0, 1'b0, 1'b0, "mid reset");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset busy", busy, 1'b0);
    check("mid reset Q", Q, 64'h0);
    check("mid reset done", done, 1'b0);
    launch(d_all(16'h1000), w_fill(16'h1000, 16'h0800, 16'h0, 16'h0), 2'b01,
           64'h0000_0000_4000_7FFF, 1'b1, 1'b1, "after reset");
    finish_run("after reset", NI + 1);

    // Random operands against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI; i++) dr[i*WL +: WL] = 16'($urandom);
      for (int i = 0; i < NI*NO; i++) wr[i*WL +: WL] = 16'($urandom);
      mr = 2'($urandom_range(0, 3));
      model(dr, wr, mr, qr, orr);
      launch(dr, wr, mr, qr, orr, 1'b1, $sformatf("random %0d", r));
      finish_run($sformatf("random %0d", r), NI + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
